// File: rtl/pdes_pkg.sv
// pdes_pkg: shared message layout, dispatcher FSM encoding and bus timing defaults
package pdes_pkg;
  localparam int BUS_GAP_DEF = 2;
  localparam int TIME_LSB = 0;
  localparam int LP_W = 8;
  localparam int HIST_W = 8;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, RECV, RISSUE, GAP} state_e;
  function automatic int lp_lsb(input int time_wid);
    return TIME_LSB + time_wid;
  endfunction
  function automatic int hist_lsb(input int msg_wid);
    return msg_wid - HIST_W;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap-around
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr + W'(k);
      idx = req[j] ? j : idx;
    end
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/event_dispatcher.sv
// event_dispatcher: moves events between the priority queue and cores over the monitored bus
module event_dispatcher
  import pdes_pkg::*;
#(
  parameter int NUM_CORE  = 4,
  parameter int NB_COREID = $clog2(NUM_CORE),
  parameter int TIME_WID  = 16,
  parameter int MSG_WID   = 32,
  parameter int BUS_GAP   = BUS_GAP_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        q_empty,
  output logic                        q_deq,
  input  logic [MSG_WID-1:0]          q_deq_data,
  input  logic                        q_full,
  output logic                        q_enq,
  output logic [MSG_WID-1:0]          q_enq_data,
  input  logic [NUM_CORE-1:0]         core_req,
  input  logic [NUM_CORE*MSG_WID-1:0] core_msg,
  output logic [NUM_CORE-1:0]         core_ack,
  input  logic [NUM_CORE-1:0]         core_done,
  output logic [NUM_CORE-1:0]         dispatch_vld,
  output logic [MSG_WID-1:0]          mon_msg,
  output logic                        mon_sent_vld,
  output logic                        mon_rcv_vld,
  output logic [NB_COREID-1:0]        mon_core_id,
  output logic [NUM_CORE-1:0]         core_active
);
  localparam int GW = $clog2(BUS_GAP + 1);
  state_e state_q, state_d;
  logic [MSG_WID-1:0] msg_q, msg_d;
  logic [NB_COREID-1:0] id_q, id_d, rr_q, rr_d, arb_idx, idle_idx;
  logic [NUM_CORE-1:0] act_q, act_d, arb_gnt;
  logic [GW-1:0] cnt_q, cnt_d;
  rr_arbiter #(.N(NUM_CORE), .W(NB_COREID)) u_arb (
    .req(core_req), .ptr(rr_q), .gnt(arb_gnt), .idx(arb_idx)
  );
  always_comb begin
    idle_idx = '0;
    for (int k = NUM_CORE - 1; k >= 0; k--) idle_idx = act_q[k] ? idle_idx : NB_COREID'(k);
  end
  // id_q is the dispatch target or the return grant; the two never overlap
  assign q_deq        = state_q == FETCH;
  assign q_enq        = state_q == RISSUE;
  assign q_enq_data   = msg_q;
  assign mon_msg      = msg_q;
  assign mon_sent_vld = state_q == ISSUE;
  assign mon_rcv_vld  = state_q == RISSUE;
  assign mon_core_id  = id_q;
  assign core_ack     = state_q == RECV ? NUM_CORE'(1) << id_q : '0;
  assign dispatch_vld = state_q == ISSUE ? NUM_CORE'(1) << id_q : '0;
  assign core_active  = act_q;
  always_comb begin
    state_d = state_q;
    msg_d = msg_q;
    id_d = id_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    act_d = (act_q & ~core_done) | dispatch_vld;
    case (state_q)
      IDLE: begin
        if (|arb_gnt && !q_full) begin
          id_d = arb_idx;
          state_d = RECV;
        end else if (!q_empty && !(&act_q)) begin
          id_d = idle_idx;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        msg_d = q_deq_data;
        state_d = ISSUE;
      end
      ISSUE: state_d = GAP;
      RECV: begin
        msg_d = core_msg[id_q*MSG_WID +: MSG_WID];
        rr_d = id_q + 1'b1;
        state_d = RISSUE;
      end
      RISSUE: state_d = GAP;
      GAP: begin
        cnt_d = cnt_q == GW'(BUS_GAP - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == GW'(BUS_GAP - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q <= '0;
      id_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      msg_q <= msg_d;
      id_q <= id_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end
endmodule

// File: tb/tb_event_dispatcher.sv
// tb_event_dispatcher: directed scenarios plus randomized traffic against a transaction-level model
module tb_event_dispatcher;
  localparam int NC = 4, NB = 2, TW = 16, MW = 32, BG = 2;
  logic clk = 0, reset = 1, q_empty = 1, q_full = 0, q_deq, q_enq, mon_sent_vld, mon_rcv_vld;
  logic [MW-1:0] q_deq_data = '0, q_enq_data, mon_msg;
  logic [NC-1:0] core_req = '0, core_done = '0, core_ack, dispatch_vld, core_active;
  logic [NC*MW-1:0] core_msg = '0;
  logic [NB-1:0] mon_core_id;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  event_dispatcher #(.NUM_CORE(NC), .NB_COREID(NB), .TIME_WID(TW), .MSG_WID(MW), .BUS_GAP(BG)) dut (
    .clk(clk), .reset(reset), .q_empty(q_empty), .q_deq(q_deq), .q_deq_data(q_deq_data),
    .q_full(q_full), .q_enq(q_enq), .q_enq_data(q_enq_data), .core_req(core_req),
    .core_msg(core_msg), .core_ack(core_ack), .core_done(core_done), .dispatch_vld(dispatch_vld),
    .mon_msg(mon_msg), .mon_sent_vld(mon_sent_vld), .mon_rcv_vld(mon_rcv_vld),
    .mon_core_id(mon_core_id), .core_active(core_active)
  );
  task automatic cyc();
    @(negedge clk);
  endtask
  function automatic int oh2i(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic do_reset();
    reset = 1; q_empty = 1; q_full = 0; core_req = '0; core_done = '0;
    cyc(); cyc();
    reset = 0;
  endtask
  task automatic test_reset();
    do_reset();
    tests++;
    if ({q_deq, q_enq, q_enq_data, core_ack, dispatch_vld, mon_msg, mon_sent_vld, mon_rcv_vld, mon_core_id, core_active} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs deq=%b ack=%b msg=%h act=%b, want all 0", q_deq, core_ack, mon_msg, core_active);
    end
  endtask
  task automatic test_first_dispatch();
    q_deq_data = 32'h0005_0010; q_empty = 0;
    cyc(); q_empty = 1;
    tests++; if (q_deq !== 1'b1 || mon_sent_vld !== 1'b0) begin fails++; $display("FAIL first_deq: q_deq=%b sent=%b, want 1 0", q_deq, mon_sent_vld); end
    cyc();
    tests++; if (q_deq !== 1'b0) begin fails++; $display("FAIL first_deq_single: q_deq=%b, want 0", q_deq); end
    cyc();
    tests++;
    if (mon_sent_vld !== 1'b1 || dispatch_vld !== 4'b0001 || mon_core_id !== 2'd0 || mon_msg !== 32'h0005_0010 || mon_rcv_vld !== 1'b0) begin
      fails++; $display("FAIL first_issue: sent=%b disp=%b id=%0d msg=%h, want 1 0001 0 00050010", mon_sent_vld, dispatch_vld, mon_core_id, mon_msg);
    end
    cyc();
    tests++; if (core_active !== 4'b0001 || mon_sent_vld !== 1'b0) begin fails++; $display("FAIL first_active: act=%b sent=%b, want 0001 0", core_active, mon_sent_vld); end
    repeat (BG) cyc();
  endtask
  task automatic test_fill();
    int ids[$];
    bit found = 0;
    q_empty = 0;
    for (int t = 0; t < 40; t++) begin
      cyc(); q_deq_data = $urandom;
      if (mon_sent_vld) ids.push_back(int'(mon_core_id));
    end
    tests++;
    if (ids.size() != 3 || ids[0] != 1 || ids[1] != 2 || ids[2] != 3 || core_active !== 4'b1111) begin
      fails++; $display("FAIL fill_order: got %0d dispatches act=%b, want 3 to cores 1,2,3 act=1111", ids.size(), core_active);
    end
    core_done = 4'b0100; cyc(); core_done = '0;
    for (int t = 0; t < 20 && !found; t++) begin
      cyc();
      if (mon_sent_vld) begin
        found = 1;
        tests++; if (mon_core_id !== 2'd2 || dispatch_vld !== 4'b0100) begin fails++; $display("FAIL fill_redispatch: id=%0d disp=%b, want 2 0100", mon_core_id, dispatch_vld); end
      end
    end
    q_empty = 1;
    tests++; if (!found) begin fails++; $display("FAIL fill_redispatch_timeout: got none, want dispatch to core 2"); end
    repeat (8) cyc();
    tests++; if (core_active !== 4'b1111) begin fails++; $display("FAIL fill_final: act=%b, want 1111", core_active); end
  endtask
  task automatic test_rr_return();
    int acks[$], rid[$], rt[$];
    logic [MW-1:0] rmsg[$];
    for (int i = 0; i < NC; i++) core_msg[i*MW +: MW] = 32'hA000_0000 | i;
    core_req = 4'b1011;
    for (int t = 0; t < 40; t++) begin
      cyc();
      if (|core_ack) begin acks.push_back(oh2i(core_ack)); core_req[oh2i(core_ack)] = 1'b0; end
      if (mon_rcv_vld) begin
        rid.push_back(int'(mon_core_id)); rmsg.push_back(mon_msg); rt.push_back(t);
        tests++;
        if (q_enq !== 1'b1 || q_enq_data !== (32'hA000_0000 | 32'(mon_core_id)) || mon_sent_vld !== 1'b0) begin
          fails++; $display("FAIL rr_enq: enq=%b data=%h id=%0d, want 1 A000000%0d", q_enq, q_enq_data, mon_core_id, mon_core_id);
        end
      end
    end
    tests++;
    if (acks.size() != 3 || acks[0] != 0 || acks[1] != 1 || acks[2] != 3) begin
      fails++; $display("FAIL rr_ack_order: got %0d acks first=%0d, want order 0,1,3", acks.size(), acks.size() > 0 ? acks[0] : -1);
    end
    tests++;
    if (rid.size() != 3 || rid[0] != 0 || rid[1] != 1 || rid[2] != 3 || rmsg[2] !== 32'hA000_0003) begin
      fails++; $display("FAIL rr_rcv: got %0d returns, want cores 0,1,3 with matching slices", rid.size());
    end
    tests++;
    if (rt.size() != 3 || rt[1] - rt[0] < 2 + BG || rt[2] - rt[1] < 2 + BG) begin
      fails++; $display("FAIL rr_spacing: got %0d returns, want spacing >= %0d", rt.size(), 2 + BG);
    end
    repeat (8) cyc();
  endtask
  task automatic test_full_priority();
    int nack = 0, kind = 0;
    bit found = 0;
    do_reset();
    core_msg[0 +: MW] = 32'hBEEF_0001; core_req = 4'b0001; q_full = 1; q_empty = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      cyc();
      if (|core_ack) nack++;
      if (mon_sent_vld) found = 1;
    end
    tests++; if (!found || nack != 0) begin fails++; $display("FAIL full_dispatch: sent=%0d acks=%0d, want 1 0", found, nack); end
    q_full = 0;
    for (int t = 0; t < 30 && kind == 0; t++) begin
      cyc();
      if (|core_ack) core_req = '0;
      if (mon_sent_vld) kind = 1;
      if (mon_rcv_vld) kind = 2;
    end
    q_empty = 1;
    tests++; if (kind != 2 || mon_msg !== 32'hBEEF_0001) begin fails++; $display("FAIL full_return_first: kind=%0d msg=%h, want 2 BEEF0001", kind, mon_msg); end
    repeat (8) cyc();
  endtask
  task automatic test_done_overlap();
    int n = 0;
    bit found = 0;
    do_reset();
    q_empty = 0;
    for (int t = 0; t < 30 && n < 2; t++) begin cyc(); if (mon_sent_vld) n++; end
    q_empty = 1;
    repeat (6) cyc();
    tests++; if (core_active !== 4'b0011) begin fails++; $display("FAIL overlap_setup: act=%b, want 0011", core_active); end
    core_done = 4'b0001; cyc(); core_done = '0;
    tests++; if (core_active !== 4'b0010) begin fails++; $display("FAIL overlap_done0: act=%b, want 0010", core_active); end
    q_empty = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      cyc();
      if (mon_sent_vld) begin
        found = 1; q_empty = 1;
        tests++; if (mon_core_id !== 2'd0) begin fails++; $display("FAIL overlap_target: id=%0d, want 0", mon_core_id); end
        core_done = 4'b1010; cyc(); core_done = '0;
        tests++; if (core_active !== 4'b0001) begin fails++; $display("FAIL overlap_both: act=%b, want 0001", core_active); end
      end
    end
    q_empty = 1;
    tests++; if (!found) begin fails++; $display("FAIL overlap_timeout: no dispatch, want one to core 0"); end
    repeat (8) cyc();
  endtask
  task automatic test_reset_mid();
    do_reset();
    q_empty = 0;
    cyc();
    tests++; if (q_deq !== 1'b1) begin fails++; $display("FAIL mid_deq: q_deq=%b, want 1", q_deq); end
    cyc();
    reset = 1; #1;
    tests++;
    if ({q_deq, q_enq, q_enq_data, core_ack, dispatch_vld, mon_msg, mon_sent_vld, mon_rcv_vld, mon_core_id, core_active} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: deq=%b sent=%b msg=%h, want all 0", q_deq, mon_sent_vld, mon_msg);
    end
    cyc(); cyc();
    reset = 0;
    tests++; if (q_deq !== 1'b0 || mon_sent_vld !== 1'b0) begin fails++; $display("FAIL mid_release: deq=%b sent=%b, want 0 0", q_deq, mon_sent_vld); end
    cyc(); q_empty = 1;
    tests++; if (q_deq !== 1'b1 || mon_sent_vld !== 1'b0) begin fails++; $display("FAIL mid_refetch: deq=%b sent=%b, want 1 0", q_deq, mon_sent_vld); end
    repeat (8) cyc();
  endtask
  task automatic test_random();
    int t0 = -10, mend = 0, kind = 0, mid = 0, rr = 0;
    logic [NC-1:0] act = '0, nact, e_ack, e_disp;
    logic [MW-1:0] mm = '0;
    logic e_deq, e_sent, e_rcv;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      e_deq = kind == 1 && c == t0 + 1;
      e_sent = kind == 1 && c == t0 + 3;
      e_rcv = kind == 2 && c == t0 + 2;
      e_ack = (kind == 2 && c == t0 + 1) ? NC'(1) << mid : '0;
      e_disp = e_sent ? NC'(1) << mid : '0;
      tests++;
      if ({q_deq, core_ack, dispatch_vld, mon_sent_vld, mon_rcv_vld, q_enq} !== {e_deq, e_ack, e_disp, e_sent, e_rcv, e_rcv}) begin
        fails++; $display("FAIL rand_strobes c=%0d: deq/ack/disp/sent/rcv/enq=%b %b %b %b %b %b, want %b %b %b %b %b %b", c,
          q_deq, core_ack, dispatch_vld, mon_sent_vld, mon_rcv_vld, q_enq, e_deq, e_ack, e_disp, e_sent, e_rcv, e_rcv);
      end
      tests++;
      if (mon_msg !== mm || (e_rcv && q_enq_data !== mm)) begin fails++; $display("FAIL rand_msg c=%0d: msg=%h enq_data=%h, want %h", c, mon_msg, q_enq_data, mm); end
      tests++;
      if (core_active !== act) begin fails++; $display("FAIL rand_active c=%0d: act=%b, want %b", c, core_active, act); end
      if (e_sent || e_rcv) begin
        tests++;
        if (int'(mon_core_id) != mid) begin fails++; $display("FAIL rand_id c=%0d: id=%0d, want %0d", c, mon_core_id, mid); end
      end
      q_empty = $urandom_range(3) == 0;
      q_full = $urandom_range(3) == 0;
      q_deq_data = $urandom;
      for (int i = 0; i < NC; i++) begin
        if (!core_req[i] && $urandom_range(7) == 0) begin core_req[i] = 1'b1; core_msg[i*MW +: MW] = $urandom; end
        core_done[i] = (e_sent && i == mid) ? 1'b0 : ($urandom_range(act[i] ? 5 : 11) == 0);
      end
      nact = (act & ~core_done) | e_disp;
      if (kind == 2 && c == t0 + 1) begin mm = core_msg[mid*MW +: MW]; rr = (mid + 1) % NC; end
      if (kind == 1 && c == t0 + 2) mm = q_deq_data;
      if (c >= mend) begin
        t0 = c; mid = -1;
        if (core_req != '0 && !q_full) begin
          kind = 2; mend = c + 3 + BG;
          for (int k = 0; k < NC; k++) if (mid < 0 && core_req[(rr + k) % NC]) mid = (rr + k) % NC;
        end else if (!q_empty && act != '1) begin
          kind = 1; mend = c + 4 + BG;
          for (int k = 0; k < NC; k++) if (mid < 0 && !act[k]) mid = k;
        end else begin
          kind = 0; mend = c + 1; mid = 0;
        end
      end
      act = nact;
      cyc();
      if (kind == 2 && c + 1 == t0 + 2) core_req[mid] = 1'b0;
    end
    core_req = '0; core_done = '0; q_empty = 1;
  endtask
  initial begin
    cyc();
    test_reset();
    test_first_dispatch();
    test_fill();
    test_rr_return();
    test_full_priority();
    test_done_overlap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
